// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREGS  = 16;
   // Widest busy vector the popcount helper can count.
   localparam int MAX_REGS   = 256;

   // Address width needed to index n registers.
   function automatic int addr_w(input int n);
      return $clog2(n);
   endfunction

   // Number of set bits in a busy vector (zero-extended to MAX_REGS).
   function automatic int popcount(input logic [MAX_REGS-1:0] v);
      int cnt;
      cnt = 0;
      for (int b = 0; b < MAX_REGS; b++) begin
         cnt = cnt + int'(v[b]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears (issue wins),
// registered popcount and combinational per-port / issue-port lookup.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS  = DEF_NREGS,
   parameter  int NRD    = 2,
   localparam int ADDR_W = addr_w(NREGS),
   localparam int CNT_W  = $clog2(NREGS + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wrEn,
   input  logic [ADDR_W-1:0]     wrAddr,
   input  logic                  issueEn,
   input  logic [ADDR_W-1:0]     issueAddr,
   input  logic [NRD*ADDR_W-1:0] rdAddr,
   output logic [NRD-1:0]        rdBusyRaw,
   output logic                  issueBusy,
   output logic [CNT_W-1:0]      busyCount
);

   logic [NREGS-1:0] busyQ;
   logic [NREGS-1:0] busyNext;

   // Next busy vector: issue to a register overrides a same-cycle clear.
   always_comb begin
      busyNext = busyQ;
      for (int r = 0; r < NREGS; r++) begin
         if (issueEn && int'(issueAddr) == r) begin
            busyNext[r] = 1'b1;
         end else if (wrEn && int'(wrAddr) == r) begin
            busyNext[r] = 1'b0;
         end
      end
   end

   // Busy vector and its popcount, both registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busyQ     <= '0;
         busyCount <= '0;
      end else begin
         busyQ     <= busyNext;
         busyCount <= CNT_W'(popcount(MAX_REGS'(busyNext)));
      end
   end

   // Busy lookups; addresses past the last register read as not busy.
   always_comb begin
      rdBusyRaw = '0;
      issueBusy = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         if (int'(rdAddr[i*ADDR_W +: ADDR_W]) < NREGS) begin
            rdBusyRaw[i] = busyQ[rdAddr[i*ADDR_W +: ADDR_W]];
         end
      end
      if (int'(issueAddr) < NREGS) begin
         issueBusy = busyQ[issueAddr];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with write bypass, PC-mapped reads,
// registered branch redirect on PC writes and a busy scoreboard.
// There is no valid/ready handshake here: writes, issues and reads are
// single-cycle strobes; decode holds off issue itself while stall is high.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int NREGS   = DEF_NREGS,
   parameter  int NRD     = 2,
   parameter  int PC_IDX  = NREGS - 1,
   parameter  int PC_OFFS = 0,
   parameter  int BYPASS  = 1,
   localparam int ADDR_W  = addr_w(NREGS),
   localparam int CNT_W   = $clog2(NREGS + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W-1:0]     pc_in,
   input  logic                  issue_en,
   input  logic [ADDR_W-1:0]     issue_addr,
   output logic                  stall,
   output logic                  pc_wr_valid,
   output logic [DATA_W-1:0]     pc_wr_data,
   output logic [CNT_W-1:0]      busy_count
);

   logic [DATA_W-1:0] mem [NREGS];
   logic              wrInRange;
   logic              wrIsPc;
   logic [NRD-1:0]    rdBusyRaw;
   logic              issueBusy;
   logic              wawHazard;
   logic [DATA_W-1:0] pcRead;

   assign wrInRange = (int'(wr_addr) < NREGS);
   assign wrIsPc    = (int'(wr_addr) == PC_IDX);
   assign pcRead    = pc_in + DATA_W'(PC_OFFS);

   reg_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_scoreboard (
      .clk       (clk),
      .reset_n   (reset_n),
      .wrEn      (wr_en),
      .wrAddr    (wr_addr),
      .issueEn   (issue_en),
      .issueAddr (issue_addr),
      .rdAddr    (rd_addr),
      .rdBusyRaw (rdBusyRaw),
      .issueBusy (issueBusy),
      .busyCount (busy_count)
   );

   // Data array: in-range, non-PC writes land at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_en && wrInRange && !wrIsPc) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Redirect register: one-cycle pulse per PC write, target held afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_wr_valid <= 1'b0;
         pc_wr_data  <= '0;
      end else begin
         pc_wr_valid <= wr_en && wrIsPc;
         if (wr_en && wrIsPc) begin
            pc_wr_data <= wr_data;
         end
      end
   end

   // Read muxes: PC index, then out-of-range zero, then bypass, then array.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (int'(rd_addr[i*ADDR_W +: ADDR_W]) == PC_IDX) begin
            rd_data[i*DATA_W +: DATA_W] = pcRead;
         end else if (int'(rd_addr[i*ADDR_W +: ADDR_W]) >= NREGS) begin
            rd_data[i*DATA_W +: DATA_W] = '0;
         end else if ((BYPASS != 0) && wr_en &&
                      (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data[i*DATA_W +: DATA_W] = wr_data;
         end else begin
            rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
         end
         if (int'(rd_addr[i*ADDR_W +: ADDR_W]) != PC_IDX) begin
            rd_busy[i] = rdBusyRaw[i] &
                         ~((BYPASS != 0) && wr_en &&
                           (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]));
         end
      end
   end

   // Hazards: RAW on any requesting port, or WAW on the issued destination
   // unless writeback is retiring that same register this cycle.
   always_comb begin
      wawHazard = issue_en && issueBusy && !(wr_en && (wr_addr == issue_addr));
      stall     = (|(rd_en & rd_busy)) || wawHazard;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 16×16 two-read/one-write register file, extending it to N read ports, configurable width and depth, write-to-read bypass, and a per-register busy scoreboard for the pipelined core. It also supports PC-mapped reads and a registered branch-redirect output for writes to the PC index. It sits in the decode/writeback boundary: decode reads operands and issues destinations, and writeback writes results and clears busy bits.

## Interface
- DATA_W, 16, register width in bits
- NREGS, 16, number of architectural registers (≥2)
- NRD, 2, number of read ports
- PC_IDX, NREGS-1, index that maps to the program counter
- PC_OFFS, 0, constant added to pc_in on PC-index reads (modulo 2^DATA_W)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding
- ADDR_W, derived $clog2(NREGS), not overridable
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  NRD  port i requests an operand (stall qualification only)
- rd_addr  in  NRD*ADDR_W  read address, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  addressed register has a pending producer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- pc_in  in  DATA_W  current PC
- issue_en  in  1  mark issue_addr busy
- issue_addr  in  ADDR_W  destination being issued
- stall  out  1  combinational hazard flag to decode
- pc_wr_valid  out  1  registered one-cycle pulse: PC was written
- pc_wr_data  out  DATA_W  redirect target, held until next PC write
- busy_count  out  $clog2(NREGS+1)  registered popcount of busy bits

## Operation
- Array write: on rising clk with wr_en=1 and wr_addr≠PC_IDX, mem[wr_addr]←wr_data and busy[wr_addr]←0.
- PC write: with wr_en=1 and wr_addr=PC_IDX, the array is untouched. Next cycle pc_wr_valid=1 and pc_wr_data=wr_data. busy[PC_IDX]←0.
- Issue: with issue_en=1, busy[issue_addr]←1 at the edge. When a write and an issue target the same address in the same cycle, issue wins and busy stays 1.
- Addresses ≥NREGS (non-power-of-2 depth):
  - Writes are ignored.
  - Issues are ignored.
  - Reads return 0 with rd_busy=0.
- Read priority, per port:
  1. addr=PC_IDX → pc_in+PC_OFFS, rd_busy=0.
  2. Out of range → 0.
  3. BYPASS=1 and wr_en and wr_addr=addr → wr_data.
  4. Otherwise mem[addr].
- rd_busy[i] = busy[addr_i] & ~(BYPASS & wr_en & wr_addr=addr_i).
- stall = OR_i(rd_en[i] & rd_busy[i]) | (issue_en & busy[issue_addr] & ~(wr_en & wr_addr=issue_addr)). The second term is the WAW hazard.
- The block does not gate its own issue on stall. Decode must drop issue_en when stall=1. An issue to an already-busy register is harmless (the bit stays 1).

## Timing
- Reset (reset_n=0, asynchronous):
  - All mem entries are 0 and all busy bits are 0.
  - pc_wr_valid=0, pc_wr_data=0, busy_count=0.
  - rd_data reflects the cleared array (PC index still returns pc_in+PC_OFFS).
- Reset asserted mid-operation discards pending writes, issues and redirects. There is no pulse after release.
- Latency:
  - Reads, rd_busy and stall: 0 cycles (combinational).
  - Writes: visible in the array after 1 edge, and in the same cycle when BYPASS=1.
  - Redirect: pc_wr_valid 1 cycle after the write edge.
  - busy_count: reflects busy state after the edge (1 cycle).
- Back-to-back PC writes give pc_wr_valid=1 on consecutive cycles, each with its own data.
- Writes to the PC index with BYPASS=1 are never forwarded. The read still returns pc_in+PC_OFFS.

## Structure
- Package regfile_pkg holds:
  - the default widths (DATA_W=16, NREGS=16);
  - function addr_w(n) = $clog2(n);
  - function popcount for busy_count.
- Sub-module reg_scoreboard(NREGS) holds the busy vector, set/clear priority, popcount register and per-port lookup.
- The top level holds the data array, read muxes, bypass and PC redirect register.

## Test plan
- Reset, then write R3←9 and R6←5 on separate cycles, then read ports (3,6) → rd_data=(9,5), stall=0.
- BYPASS=1: write R4←0x1234 with port0 reading R4 in the same cycle → rd_data0=0x1234 before the edge. With BYPASS=0 → the old value 0.
- pc_in=4, PC_OFFS=0, read R15 → 4. Write R15←0x0020 → next cycle pc_wr_valid=1, pc_wr_data=0x0020, and the pulse drops a cycle later. The R15 read stays 4.
- Issue R5, next cycle rd_en0=1 reading R5 → stall=1, busy_count=1. Then wr R5←7 with BYPASS=1 → stall=0, rd_data0=7 the same cycle, and busy_count=0 after the edge.
- Same-cycle issue R2 and write R2←1 → busy[2]=1 after the edge. A following issue R2 without a write → stall=1 (WAW).
- Issue R1, R2 and R3, then assert reset_n=0 asynchronously mid-cycle → busy_count=0, pc_wr_valid=0 and all reads 0 immediately.
